// File: rtl/serial_pkg.sv
// Shared types for the LSB-first serial link transmitter and receiver.
// Holds the shift-engine state encoding and the default frame width.
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} tx_state_t;

  localparam int SER_WIDTH = 8;

endpackage

// File: rtl/word_hold.sv
// One-entry holding register that parks the next word while a frame is shifting.
// Write latency 1 cycle; writer must check full, and wr/rd never coincide.
module word_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             r,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clock) begin
    if (r) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr) begin
      data <= wdata;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

  assign rdata = data;

endmodule

// File: rtl/shift_out_tx.sv
// Parallel-in, LSB-first serial-out transmitter; din[0] on so the cycle after accept.
// din_ready drops while the hold register is full, so at most one word queues behind the frame.
module shift_out_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clock,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr;
  logic             hold_rd;
  logic             accept;
  logic             last_bit;

  assign din_ready = !hold_full && !r;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (state == SHIFT) && (cnt == LAST);

  // Mid-frame words park in hold; on the last bit an empty hold is bypassed.
  assign hold_wr = accept && (state == SHIFT) && !last_bit;
  assign hold_rd = last_bit && hold_full;

  word_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock(clock),
    .r    (r),
    .wr   (hold_wr),
    .wdata(din),
    .rd   (hold_rd),
    .rdata(hold_data),
    .full (hold_full)
  );

  // Outputs are registered alongside the state so they track state/cnt/shreg exactly.
  always_ff @(posedge clock) begin
    if (r) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      so_first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= SHIFT;
            shreg    <= din;
            cnt      <= '0;
            so       <= din[0];
            so_valid <= 1'b1;
            so_first <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            shreg    <= shreg >> 1;
            cnt      <= cnt + 1'b1;
            so       <= shreg[1];
            so_valid <= 1'b1;
            so_first <= 1'b0;
          end else if (hold_full) begin
            shreg    <= hold_data;
            cnt      <= '0;
            so       <= hold_data[0];
            so_valid <= 1'b1;
            so_first <= 1'b1;
          end else if (accept) begin
            shreg    <= din;
            cnt      <= '0;
            so       <= din[0];
            so_valid <= 1'b1;
            so_first <= 1'b1;
          end else begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_first <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_shift_out_tx.sv
// Directed bench for shift_out_tx: reset, single frame, back-to-back, last-bit bypass,
// mid-frame reset and loopback into an LSB-first serial-in receiver model.
module tb_shift_out_tx;

  logic       clock = 1'b0;
  logic       r = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       so;
  logic       so_valid;
  logic       so_first;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  shift_out_tx #(.WIDTH(8)) dut (
    .clock    (clock),
    .r        (r),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .so       (so),
    .so_valid (so_valid),
    .so_first (so_first),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Receiver model: shifts in on so_valid cycles, restarts on so_first.
  logic [7:0] rx_word = 8'h00;
  int         rx_bits = 0;
  logic [7:0] rxq[$];

  always @(negedge clock) begin
    if (so_valid) begin
      if (so_first) rx_bits = 0;
      rx_word = {so, rx_word[7:1]};
      rx_bits = rx_bits + 1;
      if (rx_bits == 8) rxq.push_back(rx_word);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1;
    din_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_high: din_ready=%b want 0", din_ready); end
    n_tests++;
    if (so_valid !== 1'b0) begin n_fail++; $display("FAIL reset_so_valid: so_valid=%b want 0", so_valid); end
    r = 1'b0;
    #1;
    n_tests++;
    if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_after: din_ready=%b want 1", din_ready); end
    n_tests++;
    if ({so_valid, so, so_first, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle_outs: valid/so/first/busy=%b want 0000", {so_valid, so, so_first, busy});
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;  // so order bit0..bit7 = 1,0,1,0,0,1,0,1
    din = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (so_valid !== 1'b1 || so !== exp_bits[k] || so_first !== (k == 0) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_bit%0d: valid=%b so=%b first=%b busy=%b want 1 %b %b 1",
                 k, so_valid, so, so_first, busy, exp_bits[k], (k == 0));
      end
      tick();
    end
    n_tests++;
    if (so_valid !== 1'b0 || busy !== 1'b0 || so !== 1'b0) begin
      n_fail++; $display("FAIL single_end: valid=%b busy=%b so=%b want 0 0 0", so_valid, busy, so);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits;
    logic        exp_rdy;
    exp_bits = 16'b1111_0000_0000_1111;  // 0F then F0, LSB first from bit 0 up
    din = 8'h0F;
    din_valid = 1'b1;
    tick();
    din = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      exp_rdy = !(i >= 1 && i <= 7);
      n_tests++;
      if (so_valid !== 1'b1 || so !== exp_bits[i] || so_first !== (i == 0 || i == 8) || din_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: valid=%b so=%b first=%b rdy=%b want 1 %b %b %b",
                 i, so_valid, so, so_first, din_ready, exp_bits[i], (i == 0 || i == 8), exp_rdy);
      end
      tick();
      din_valid = 1'b0;
    end
    n_tests++;
    if (so_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: valid=%b busy=%b want 0 0", so_valid, busy);
    end
  endtask

  task automatic test_last_bit_bypass();
    logic [15:0] exp_bits;
    exp_bits = 16'b1100_0110_0011_0011;  // 33 then C6
    din = 8'h33;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        din = 8'hC6;
        din_valid = 1'b1;
        n_tests++;
        if (din_ready !== 1'b1 || busy !== 1'b1) begin
          n_fail++; $display("FAIL bypass_rdy: din_ready=%b busy=%b want 1 1", din_ready, busy);
        end
      end
      n_tests++;
      if (so_valid !== 1'b1 || so !== exp_bits[i] || so_first !== (i == 0 || i == 8)) begin
        n_fail++;
        $display("FAIL bypass_bit%0d: valid=%b so=%b first=%b want 1 %b %b",
                 i, so_valid, so, so_first, exp_bits[i], (i == 0 || i == 8));
      end
      tick();
      din_valid = 1'b0;
    end
    n_tests++;
    if (so_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_end: so_valid=%b want 0", so_valid); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_bits;
    exp_bits = 8'h3C;
    din = 8'hFF;
    din_valid = 1'b1;
    tick();
    din = 8'h81;
    tick();
    din_valid = 1'b0;
    n_tests++;
    if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_held: din_ready=%b want 0", din_ready); end
    tick();
    tick();
    r = 1'b1;
    #1;
    n_tests++;
    if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_rdy_in_r: din_ready=%b want 0", din_ready); end
    tick();
    n_tests++;
    if (so_valid !== 1'b0 || busy !== 1'b0 || so !== 1'b0 || dut.hold_full !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: valid=%b busy=%b so=%b hold_full=%b want 0 0 0 0",
                         so_valid, busy, so, dut.hold_full);
    end
    r = 1'b0;
    tick();
    n_tests++;
    if (so_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_idle: valid=%b rdy=%b want 0 1", so_valid, din_ready);
    end
    din = 8'h3C;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (so_valid !== 1'b1 || so !== exp_bits[k] || so_first !== (k == 0)) begin
        n_fail++; $display("FAIL midrst_bit%0d: valid=%b so=%b first=%b want 1 %b %b",
                           k, so_valid, so, so_first, exp_bits[k], (k == 0));
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (so_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resume%0d: so_valid=%b want 0", k, so_valid); end
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] words[4];
    int         t;
    words[0] = 8'hA5;
    words[1] = 8'h5A;
    words[2] = 8'h01;
    words[3] = 8'h80;
    rxq.delete();
    for (int w = 0; w < 4; w++) begin
      din = words[w];
      din_valid = 1'b1;
      t = 0;
      while (!din_ready && t < 40) begin
        tick();
        t++;
      end
      n_tests++;
      if (!din_ready) begin n_fail++; $display("FAIL loop_accept%0d: din_ready=%b want 1 within 40 cycles", w, din_ready); end
      tick();
    end
    din_valid = 1'b0;
    t = 0;
    while (rxq.size() < 4 && t < 80) begin
      tick();
      t++;
    end
    n_tests++;
    if (rxq.size() != 4) begin n_fail++; $display("FAIL loop_count: frames=%0d want 4", rxq.size()); end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (w >= rxq.size()) begin
        n_fail++; $display("FAIL loop_word%0d: missing want %h", w, words[w]);
      end else if (rxq[w] !== words[w]) begin
        n_fail++; $display("FAIL loop_word%0d: got %h want %h", w, rxq[w], words[w]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_last_bit_bypass();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
